// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice roller.
//   chan_state_e : per-player channel state
//   face_of      : maps a 3-bit LFSR slice onto a die face 1..6
//   lfsr_step    : one shift of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package dice_pkg;

  localparam int unsigned DICE_W   = 4;
  localparam int unsigned FACE_MIN = 1;
  localparam int unsigned FACE_MAX = 6;
  localparam int unsigned LFSR_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    DONE = 2'd2
  } chan_state_e;

  // Slice values 6 and 7 fold back onto 0 and 1 before the +1 offset.
  function automatic logic [DICE_W-1:0] face_of(input logic [2:0] v);
    logic [2:0] r;
    r = (v >= 3'(FACE_MAX)) ? v - 3'(FACE_MAX) : v;
    return DICE_W'(r) + DICE_W'(FACE_MIN);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/dice_roller_if.sv
// Dice result bus between the roller (master) and the score block (slave).
//   dice1/dice2  : player faces, 0 after reset, else 1..6
//   rolling1/2   : roll animation in progress
//   round_valid  : one-cycle pulse, both faces final
//   finish       : game over from score, blocks all rolls
interface dice_roller_if;
  import dice_pkg::*;

  logic [DICE_W-1:0] dice1;
  logic [DICE_W-1:0] dice2;
  logic              rolling1;
  logic              rolling2;
  logic              round_valid;
  logic              finish;

  modport master (
    output dice1, dice2, rolling1, rolling2, round_valid,
    input  finish
  );

  modport slave (
    input  dice1, dice2, rolling1, rolling2, round_valid,
    output finish
  );

endinterface

// File: rtl/dice_channel.sv
// One player's roll channel: button synchronizer, rising-edge register,
// IDLE/ROLL/DONE state machine, roll and flicker counters, face register.
//   start     : raw button
//   finish    : abort / block rolls
//   close     : round closing, DONE returns to IDLE
//   sample    : 3-bit LFSR slice for this player
//   face      : registered die face
//   rolling   : registered, high while in ROLL
//   done      : channel currently in DONE
//   done_next : channel will be in DONE after this edge
module dice_channel
  import dice_pkg::*;
#(
  parameter int unsigned ROLL_CYCLES    = 25_000_000,
  parameter int unsigned FLICKER_CYCLES = 2_500_000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              close,
  input  logic [2:0]        sample,
  output logic [DICE_W-1:0] face,
  output logic              rolling,
  output logic              done,
  output logic              done_next
);

  localparam int unsigned RW = $clog2(ROLL_CYCLES);
  localparam int unsigned FW = (FLICKER_CYCLES > 1) ? $clog2(FLICKER_CYCLES) : 1;
  localparam logic [RW-1:0] ROLL_LAST  = RW'(ROLL_CYCLES - 1);
  localparam logic [FW-1:0] FLICK_LAST = FW'(FLICKER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   rise;

  chan_state_e state;
  chan_state_e state_next;
  logic [RW-1:0] roll_cnt;
  logic [RW-1:0] roll_cnt_next;
  logic [FW-1:0] flick_cnt;
  logic [FW-1:0] flick_cnt_next;
  logic          load;

  // Registered rise puts the roll start SYNC_STAGES+1 clocks after sampling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= '0;
      sync_prev <= 1'b0;
      rise      <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], start};
      sync_prev <= sync[SYNC_STAGES-1];
      rise      <= sync[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  always_comb begin
    state_next     = state;
    roll_cnt_next  = roll_cnt;
    flick_cnt_next = flick_cnt;
    load           = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise && !finish) begin
          state_next     = ROLL;
          roll_cnt_next  = '0;
          flick_cnt_next = '0;
          load           = 1'b1;
        end
      end
      ROLL: begin
        if (finish) begin
          state_next = IDLE;
        end else if (roll_cnt == ROLL_LAST) begin
          state_next = DONE;
          load       = 1'b1;
        end else begin
          roll_cnt_next = roll_cnt + 1'b1;
          if (flick_cnt == FLICK_LAST) begin
            flick_cnt_next = '0;
            load           = 1'b1;
          end else begin
            flick_cnt_next = flick_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        if (finish || close) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      roll_cnt  <= '0;
      flick_cnt <= '0;
      face      <= '0;
      rolling   <= 1'b0;
    end else begin
      state     <= state_next;
      roll_cnt  <= roll_cnt_next;
      flick_cnt <= flick_cnt_next;
      rolling   <= (state_next == ROLL);
      if (load) begin
        face <= face_of(sample);
      end
    end
  end

  assign done      = (state == DONE);
  assign done_next = (state_next == DONE);

endmodule

// File: rtl/dice_roller.sv
// Dice roller top: shared free-running LFSR, two player channels,
// round-close detection and finish fan-out.
//   clk, rst       : clock, asynchronous active-low reset
//   start1, start2 : raw player buttons
//   bus (master)   : dice1/dice2, rolling1/rolling2, round_valid out; finish in
module dice_roller
  import dice_pkg::*;
#(
  parameter int unsigned       ROLL_CYCLES    = 25_000_000,
  parameter int unsigned       FLICKER_CYCLES = 2_500_000,
  parameter int unsigned       SYNC_STAGES    = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start1,
  input  logic          start2,
  dice_roller_if.master bus
);

  logic [LFSR_W-1:0] lfsr;
  logic done1;
  logic done2;
  logic done_next1;
  logic done_next2;
  logic close;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // Both channels sitting in DONE releases them on the following edge.
  assign close = done1 & done2;

  dice_channel #(
    .ROLL_CYCLES   (ROLL_CYCLES),
    .FLICKER_CYCLES(FLICKER_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_ch1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start1),
    .finish   (bus.finish),
    .close    (close),
    .sample   (lfsr[2:0]),
    .face     (bus.dice1),
    .rolling  (bus.rolling1),
    .done     (done1),
    .done_next(done_next1)
  );

  dice_channel #(
    .ROLL_CYCLES   (ROLL_CYCLES),
    .FLICKER_CYCLES(FLICKER_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_ch2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .finish   (bus.finish),
    .close    (close),
    .sample   (lfsr[10:8]),
    .face     (bus.dice2),
    .rolling  (bus.rolling2),
    .done     (done2),
    .done_next(done_next2)
  );

  // Pulse lands in the first cycle both channels hold DONE; close then
  // forces both next states away from DONE, so it cannot repeat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.round_valid <= 1'b0;
    end else begin
      bus.round_valid <= done_next1 & done_next2;
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
module tb_dice_roller;

  localparam int R      = 20;
  localparam int F      = 4;
  localparam int S      = 2;
  localparam int ROUNDS = 2000;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  logic start1;
  logic start2;

  dice_roller_if dif ();

  dice_roller #(
    .ROLL_CYCLES   (R),
    .FLICKER_CYCLES(F),
    .SYNC_STAGES   (S),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start1(start1),
    .start2(start2),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Timeline view: edge k counts clocks since reset; a button rise seen at
  // edge k starts a roll at edge k+S+1; roll started at edge r shows new
  // faces at r, r+F, r+2F, ... and settles at r+R.
  typedef enum int {M_IDLE, M_ROLL, M_DONE} mst_e;

  mst_e        m_st [2] = '{M_IDLE, M_IDLE};
  int          m_r  [2] = '{0, 0};
  bit          m_sprev [2] = '{0, 0};
  bit          m_press [2][8];
  int          m_face [2] = '{0, 0};
  bit          m_rv = 1'b0;
  logic [15:0] m_lfsr = SEED;
  int          m_k = 0;

  function automatic int face_val(input int v);
    return (v % 6) + 1;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit s [2];
    bit f;
    bit bd;
    bit armed;
    int j;
    int v;
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        m_st[p] = M_IDLE; m_r[p] = 0; m_sprev[p] = 0; m_face[p] = 0;
        for (int q = 0; q < 8; q++) m_press[p][q] = 0;
      end
      m_rv = 0; m_lfsr = SEED; m_k = 0;
    end else begin
      m_k++;
      s[0] = start1; s[1] = start2; f = dif.finish;
      bd = (m_st[0] == M_DONE) && (m_st[1] == M_DONE);
      for (int p = 0; p < 2; p++) begin
        v = (p == 0) ? int'(m_lfsr[2:0]) : int'(m_lfsr[10:8]);
        m_press[p][m_k % 8] = s[p] && !m_sprev[p];
        m_sprev[p] = s[p];
        armed = (m_k >= S + 1) && m_press[p][(m_k - S - 1) % 8];
        case (m_st[p])
          M_IDLE: if (armed && !f) begin
            m_st[p] = M_ROLL; m_r[p] = m_k; m_face[p] = face_val(v);
          end
          M_ROLL: begin
            j = m_k - m_r[p];
            if (f) m_st[p] = M_IDLE;
            else if (j == R) begin m_st[p] = M_DONE; m_face[p] = face_val(v); end
            else if (j % F == 0) m_face[p] = face_val(v);
          end
          default: if (f || bd) m_st[p] = M_IDLE;
        endcase
      end
      m_rv = (m_st[0] == M_DONE) && (m_st[1] == M_DONE) && !bd;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // ---------------- per-cycle monitor ----------------
  int roll1_cyc = 0, roll2_cyc = 0, rv_cnt = 0;
  int hist1 [16];
  int hist2 [16];

  always @(negedge clk) begin
    check("rolling1", dif.rolling1, m_st[0] == M_ROLL);
    check("rolling2", dif.rolling2, m_st[1] == M_ROLL);
    check("dice1", dif.dice1, m_face[0]);
    check("dice2", dif.dice2, m_face[1]);
    check("round_valid", dif.round_valid, m_rv);
    if (rst === 1'b1) begin
      if (dif.rolling1) roll1_cyc++;
      if (dif.rolling2) roll2_cyc++;
      if (dif.round_valid) begin
        rv_cnt++;
        hist1[dif.dice1]++;
        hist2[dif.dice2]++;
      end
    end
  end

  // ---------------- directed scenario table ----------------
  typedef struct {
    string name;
    int p1a; int hold1; int p1b; int p2; int fin_at; int fin_len;
    int e_roll1; int e_roll2; int e_rv;
  } vec_t;

  function automatic vec_t mk(input string n, input int p1a, input int hold1, input int p1b,
                              input int p2, input int fin_at, input int fin_len,
                              input int e1, input int e2, input int erv);
    vec_t t;
    t.name = n; t.p1a = p1a; t.hold1 = hold1; t.p1b = p1b; t.p2 = p2;
    t.fin_at = fin_at; t.fin_len = fin_len;
    t.e_roll1 = e1; t.e_roll2 = e2; t.e_rv = erv;
    return t;
  endfunction

  task automatic flush();
    @(negedge clk); start1 = 0; start2 = 0; dif.finish = 1;
    @(negedge clk); dif.finish = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [10];
    int b1, b2, brv, first, len, got;
    int o1, o2, h1, h2;
    bit re;

    for (int i = 0; i < 16; i++) begin hist1[i] = 0; hist2[i] = 0; end
    rst = 1'b0; start1 = 0; start2 = 0; dif.finish = 0;

    // reset hold and release
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("rst_dice1", dif.dice1, 0);
    check("rst_dice2", dif.dice2, 0);
    check("rst_rolling1", dif.rolling1, 0);
    check("rst_rolling2", dif.rolling2, 0);
    check("rst_round_valid", dif.round_valid, 0);

    // start latency and roll length
    @(negedge clk); start1 = 1;
    first = -1; len = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start1 = 0;
      if (dif.rolling1) begin
        if (first < 0) first = n;
        len++;
      end
    end
    check("start_latency", first - 1, S + 1);
    check("roll_length", len, R);
    flush();

    // asynchronous reset in the middle of a roll
    @(negedge clk); start1 = 1;
    @(negedge clk); start1 = 0;
    repeat (9) @(negedge clk);
    check("pre_rst_rolling1", dif.rolling1, 1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("async_rst_rolling1", dif.rolling1, 0);
    check("async_rst_dice1", dif.dice1, 0);
    check("async_rst_round_valid", dif.round_valid, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven scenarios
    tv[0] = mk("p1_only",     0,  1, -1, -1, -1,  0, 20,  0, 0);
    tv[1] = mk("p2_lag8",     0,  1, -1,  8, -1,  0, 20, 20, 1);
    tv[2] = mk("simultaneous",0,  1, -1,  0, -1,  0, 20, 20, 1);
    tv[3] = mk("hold50",      0, 50, -1, -1, -1,  0, 20,  0, 0);
    tv[4] = mk("repress",     0,  1, 10, -1, -1,  0, 20,  0, 0);
    tv[5] = mk("finish_mid",  0,  1, -1, 15, 13, 20, 10,  0, 0);
    tv[6] = mk("finish_done", 0,  1, -1, 40, 30,  2, 20, 20, 0);
    tv[7] = mk("finish_pre",  2,  1, -1, -1,  0, 10,  0,  0, 0);
    tv[8] = mk("p2_only",    -1,  1, -1,  5, -1,  0,  0, 20, 0);
    tv[9] = mk("done_ignore", 0,  1, 30, 35, -1,  0, 20, 20, 1);

    for (int i = 0; i < 10; i++) begin
      b1 = roll1_cyc; b2 = roll2_cyc; brv = rv_cnt;
      for (int c = 0; c < 90; c++) begin
        @(negedge clk);
        start1 = (tv[i].p1a >= 0 && c >= tv[i].p1a && c < tv[i].p1a + tv[i].hold1) ||
                 (tv[i].p1b >= 0 && c == tv[i].p1b);
        start2 = (tv[i].p2 >= 0 && c == tv[i].p2);
        dif.finish = (tv[i].fin_at >= 0 && c >= tv[i].fin_at && c < tv[i].fin_at + tv[i].fin_len);
      end
      flush();
      check({tv[i].name, "_roll1"}, roll1_cyc - b1, tv[i].e_roll1);
      check({tv[i].name, "_roll2"}, roll2_cyc - b2, tv[i].e_roll2);
      check({tv[i].name, "_rv"}, rv_cnt - brv, tv[i].e_rv);
    end

    // randomized rounds
    brv = rv_cnt;
    for (int r = 0; r < ROUNDS; r++) begin
      o1 = $urandom_range(0, 6); o2 = $urandom_range(0, 6);
      h1 = $urandom_range(1, 4); h2 = $urandom_range(1, 4);
      re = ($urandom_range(0, 3) == 0);
      got = 0;
      for (int c = 0; c < 80 && got == 0; c++) begin
        @(negedge clk);
        if (dif.round_valid) begin
          got = 1;
          check("rv_face1_range", dif.dice1 inside {[1:6]}, 1);
          check("rv_face2_range", dif.dice2 inside {[1:6]}, 1);
        end
        start1 = (c >= o1 && c < o1 + h1) || (re && c == o1 + 9);
        start2 = (c >= o2 && c < o2 + h2);
      end
      start1 = 0; start2 = 0;
      check("round_completes", got, 1);
    end
    repeat (2) @(negedge clk);
    check("rv_count", rv_cnt - brv, ROUNDS);
    for (int fv = 1; fv <= 6; fv++) begin
      check("cover_dice1", hist1[fv] > 0, 1);
      check("cover_dice2", hist2[fv] > 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
